// File: rtl/conv_pkg.sv
// Shared constants, tag widths and stream state encoding for the convolution
// datapath and its output streamer.
package conv_pkg;
  localparam int IN_H = 8;
  localparam int IN_W = 8;
  localparam int K    = 3;
  localparam int CH   = 3;
  localparam int OH   = IN_H - K + 1;
  localparam int OW   = IN_W - K + 1;
  localparam int DW   = 8;

  localparam int FRAME_ELEMS = CH * OH * OW;
  localparam int BUS_W       = FRAME_ELEMS * DW;

  localparam int CH_W   = $clog2(CH);
  localparam int ROW_W  = $clog2(OH);
  localparam int COL_W  = $clog2(OW);
  localparam int IDX_W  = $clog2(FRAME_ELEMS);
  localparam int BASE_W = $clog2(BUS_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;
endpackage

// File: rtl/conv_idx_cnt.sv
// Nested column/row/channel wrapping counter giving element coordinates,
// the flat channel-major index and a final-element flag.
module conv_idx_cnt
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [COL_W-1:0] c,
  output logic [ROW_W-1:0] r,
  output logic [CH_W-1:0]  d,
  output logic [IDX_W-1:0] idx,
  output logic             last
);
  logic [COL_W-1:0] c_q, c_d;
  logic [ROW_W-1:0] r_q, r_d;
  logic [CH_W-1:0]  d_q, d_d;

  logic c_wrap, r_wrap, d_wrap;

  assign c_wrap = (c_q == COL_W'(OW - 1));
  assign r_wrap = (r_q == ROW_W'(OH - 1));
  assign d_wrap = (d_q == CH_W'(CH - 1));

  always_comb begin
    c_d = c_q;
    r_d = r_q;
    d_d = d_q;
    if (clear) begin
      c_d = '0;
      r_d = '0;
      d_d = '0;
    end else if (en) begin
      // Column is the fastest-moving coordinate; the last element wraps to (0,0,0).
      c_d = c_wrap ? '0 : c_q + 1'b1;
      if (c_wrap) begin
        r_d = r_wrap ? '0 : r_q + 1'b1;
        if (r_wrap) begin
          d_d = d_wrap ? '0 : d_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      r_q <= '0;
      d_q <= '0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
      d_q <= d_d;
    end
  end

  assign c    = c_q;
  assign r    = r_q;
  assign d    = d_q;
  assign idx  = IDX_W'(d_q) * IDX_W'(OH * OW) + IDX_W'(r_q) * IDX_W'(OW) + IDX_W'(c_q);
  assign last = c_wrap && r_wrap && d_wrap;
endmodule

// File: rtl/conv_out_streamer.sv
// Captures the flat convolution result bus on start and streams it out one
// element per valid/ready transfer in channel-major order with coordinate tags.
module conv_out_streamer
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BUS_W-1:0] conv_lin,
  output logic             busy,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CH_W-1:0]  out_ch,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             done
);
  state_e state_q, state_d;
  logic [BUS_W-1:0] shadow_q, shadow_d;

  logic             start_acc;
  logic             xfer;
  logic             in_stream;
  logic [COL_W-1:0] cnt_c;
  logic [ROW_W-1:0] cnt_r;
  logic [CH_W-1:0]  cnt_d;
  logic [IDX_W-1:0] cnt_idx;
  logic             cnt_last;
  logic [BASE_W-1:0] bit_base;

  conv_idx_cnt u_idx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_acc),
    .en    (xfer),
    .c     (cnt_c),
    .r     (cnt_r),
    .d     (cnt_d),
    .idx   (cnt_idx),
    .last  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    start_acc = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        xfer = out_ready;
        if (out_ready && cnt_last) state_d = DONE;
      end
      DONE: begin
        // A start in the DONE cycle chains straight into the next frame.
        if (start) begin
          start_acc = 1'b1;
          state_d   = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_acc) shadow_d = conv_lin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  assign in_stream = (state_q == STREAM);
  assign bit_base  = BASE_W'(cnt_idx) * BASE_W'(DW);

  // Data and tags read as zero whenever no element is being offered.
  assign out_valid = in_stream;
  assign busy      = in_stream;
  assign done      = (state_q == DONE);
  assign out_last  = in_stream && cnt_last;
  assign out_data  = in_stream ? shadow_q[bit_base +: DW] : '0;
  assign out_ch    = in_stream ? cnt_d : '0;
  assign out_row   = in_stream ? cnt_r : '0;
  assign out_col   = in_stream ? cnt_c : '0;
endmodule
